// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode constants, instruction field positions and fetch FSM state encoding
//
// Purpose: shared definitions for the instruction fetch unit and its decoder.
// Contents:
//   OP_*        4-bit opcode constants of the supported instruction set
//   *_MSB/*_LSB bit positions of the op, r1, r2 and imm fields inside the 16-bit IR
//   ST_*        encoding of the fetch FSM states (IDLE, FETCH, DECODE, ISSUE, HALT)
package isa_pkg;

  localparam int IR_W    = 16;
  localparam int PC_W    = 8;

  // Instruction word layout: [15:12] op, [11:9] r1, [8:6] r2, [8:0] imm.
  // r2 and imm overlap; which one is meaningful depends on the opcode.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int R1_MSB  = 11;
  localparam int R1_LSB  = 9;
  localparam int R2_MSB  = 8;
  localparam int R2_LSB  = 6;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational field extraction and opcode legality check
//
// Purpose: splits an instruction word into its fields and flags whether the
// opcode belongs to the supported set. No state.
// Ports:
//   ir     in   16  instruction word
//   op     out  4   ir[15:12]
//   r1     out  3   ir[11:9]
//   r2     out  3   ir[8:6]
//   imm    out  9   ir[8:0]
//   legal  out  1   op is one of NOP, ADD, ADDI, ST, LD
module instr_decoder
  import isa_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output logic [3:0]      op,
  output logic [2:0]      r1,
  output logic [2:0]      r2,
  output logic [8:0]      imm,
  output logic            legal
);

  always_comb begin
    op  = ir[OP_MSB:OP_LSB];
    r1  = ir[R1_MSB:R1_LSB];
    r2  = ir[R2_MSB:R2_LSB];
    imm = ir[IMM_MSB:IMM_LSB];
    case (ir[OP_MSB:OP_LSB])
      OP_NOP, OP_ADD, OP_ADDI, OP_ST, OP_LD: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential fetch/decode/issue engine for a small ROM program
//
// Purpose: walks a ROM from address 0, decodes each word and presents it to the
// datapath with a valid/ready handshake, halting after PC_LAST or on an unknown opcode.
// Parameters:
//   PC_LAST   address of the last instruction executed before halt
//   SKIP_NOP  1: opcode 0000 is consumed without being issued
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous active-high reset
//   start       in   1   level, leaves IDLE when sampled high
//   rom_addr    out  8   instruction address (always equal to the internal pc)
//   rom_data    in   16  ROM word, combinational from rom_addr
//   out_valid   out  1   decoded instruction available (ISSUE only)
//   out_ready   in   1   datapath accepts the instruction
//   op/r1/r2/imm out     decoded fields of the instruction being issued
//   pc_out      out  8   address of the instruction on op/r1/r2/imm
//   halted      out  1   high in HALT
//   illegal_op  out  1   sticky, an unknown opcode was decoded
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_LAST  = 8'd6,
  parameter bit              SKIP_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] rom_addr,
  input  logic [IR_W-1:0] rom_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      op,
  output logic [2:0]      r1,
  output logic [2:0]      r2,
  output logic [8:0]      imm,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic            illegal_op
);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [IR_W-1:0] ir;

  logic [3:0]      dec_op;
  logic [2:0]      dec_r1;
  logic [2:0]      dec_r2;
  logic [8:0]      dec_imm;
  logic            dec_legal;

  logic            skip_nop_now;
  logic            handshake;
  logic            advance;
  logic            at_last;

  instr_decoder u_decoder (
    .ir    (ir),
    .op    (dec_op),
    .r1    (dec_r1),
    .r2    (dec_r2),
    .imm   (dec_imm),
    .legal (dec_legal)
  );

  // The ROM is addressed straight from the pc register, so rom_addr only moves
  // when pc does (never on the FETCH edge that loads the IR).
  assign rom_addr = pc;

  // Two ways to retire the current instruction: a skipped NOP in DECODE or an
  // accepted handshake in ISSUE. Both share the same pc-advance logic below.
  assign skip_nop_now = (state == ST_DECODE) && dec_legal && (dec_op == OP_NOP) && SKIP_NOP;
  assign handshake    = (state == ST_ISSUE) && out_valid && out_ready;
  assign advance      = skip_nop_now || handshake;
  assign at_last      = (pc == PC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      ir         <= '0;
      out_valid  <= 1'b0;
      op         <= '0;
      r1         <= '0;
      r2         <= '0;
      imm        <= '0;
      pc_out     <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          ir    <= rom_data;
          state <= ST_DECODE;
        end

        ST_DECODE: begin
          op     <= dec_op;
          r1     <= dec_r1;
          r2     <= dec_r2;
          imm    <= dec_imm;
          pc_out <= pc;
          if (!dec_legal) begin
            illegal_op <= 1'b1;
            halted     <= 1'b1;
            state      <= ST_HALT;
          end else if (!skip_nop_now) begin
            out_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (handshake) begin
            out_valid <= 1'b0;
          end
        end

        ST_HALT: begin
          // Absorbing until reset; pc (and so rom_addr) stays frozen.
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase

      // Retiring the instruction at PC_LAST halts instead of incrementing,
      // so the pc never wraps even when PC_LAST is 255.
      if (advance) begin
        if (at_last) begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end else begin
          pc    <= pc + 8'd1;
          state <= ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [8:0] imm;
    logic [7:0] pc;
  } exp_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] word;
    logic [3:0]  op;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [8:0]  imm;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [256];

  // DUT A: default parameters
  logic rst_a, start_a, ready_a, valid_a, halted_a, ill_a;
  logic [7:0] addr_a, pcout_a;
  logic [15:0] data_a;
  logic [3:0] op_a;
  logic [2:0] r1_a, r2_a;
  logic [8:0] imm_a;
  assign data_a = rom[addr_a];

  // DUT B: SKIP_NOP = 0
  logic rst_b, start_b, ready_b, valid_b, halted_b, ill_b;
  logic [7:0] addr_b, pcout_b;
  logic [15:0] data_b;
  logic [3:0] op_b;
  logic [2:0] r1_b, r2_b;
  logic [8:0] imm_b;
  assign data_b = rom[addr_b];

  // DUT C: PC_LAST = 255, every ROM word is 0x1000
  logic rst_c, start_c, ready_c, valid_c, halted_c, ill_c;
  logic [7:0] addr_c, pcout_c;
  logic [15:0] data_c;
  logic [3:0] op_c;
  logic [2:0] r1_c, r2_c;
  logic [8:0] imm_c;
  assign data_c = 16'h1000;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst_a), .start(start_a), .rom_addr(addr_a), .rom_data(data_a),
    .out_valid(valid_a), .out_ready(ready_a), .op(op_a), .r1(r1_a), .r2(r2_a),
    .imm(imm_a), .pc_out(pcout_a), .halted(halted_a), .illegal_op(ill_a)
  );

  instr_fetch_unit #(.SKIP_NOP(1'b0)) u_nop (
    .clk(clk), .rst(rst_b), .start(start_b), .rom_addr(addr_b), .rom_data(data_b),
    .out_valid(valid_b), .out_ready(ready_b), .op(op_b), .r1(r1_b), .r2(r2_b),
    .imm(imm_b), .pc_out(pcout_b), .halted(halted_b), .illegal_op(ill_b)
  );

  instr_fetch_unit #(.PC_LAST(8'd255)) u_wrap (
    .clk(clk), .rst(rst_c), .start(start_c), .rom_addr(addr_c), .rom_data(data_c),
    .out_valid(valid_c), .out_ready(ready_c), .op(op_c), .r1(r1_c), .r2(r2_c),
    .imm(imm_c), .pc_out(pcout_c), .halted(halted_c), .illegal_op(ill_c)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;
  logic gap_chk_a = 1'b0;
  int   last_a    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_issue(input string tag, input exp_t e, input logic [3:0] o,
                           input logic [2:0] a, input logic [2:0] b,
                           input logic [8:0] im, input logic [7:0] p);
    check({tag, "_op"}, 32'(o), 32'(e.op));
    check({tag, "_r1"}, 32'(a), 32'(e.r1));
    check({tag, "_r2"}, 32'(b), 32'(e.r2));
    check({tag, "_imm"}, 32'(im), 32'(e.imm));
    check({tag, "_pc_out"}, 32'(p), 32'(e.pc));
  endtask

  task automatic unexpected(input string tag, input logic [7:0] p);
    checks++;
    fails++;
    $display("FAIL %s_unexpected_issue: got issue at pc_out %0d, expected none", tag, p);
  endtask

  // Scoreboard monitors: an issue is accepted at the edge following a
  // valid&&ready sample, unless reset is asserted on that edge.
  always @(negedge clk) begin
    if (valid_a && ready_a && !rst_a) begin
      if (qa.size() == 0) unexpected("a", pcout_a);
      else begin
        ea = qa.pop_front();
        cmp_issue("a", ea, op_a, r1_a, r2_a, imm_a, pcout_a);
      end
      if (gap_chk_a && last_a >= 0) check("a_issue_gap", 32'(cyc - last_a), 32'd3);
      last_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (valid_b && ready_b && !rst_b) begin
      if (qb.size() == 0) unexpected("b", pcout_b);
      else begin
        eb = qb.pop_front();
        cmp_issue("b", eb, op_b, r1_b, r2_b, imm_b, pcout_b);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_c && ready_c && !rst_c) begin
      if (qc.size() == 0) unexpected("c", pcout_c);
      else begin
        ec = qc.pop_front();
        cmp_issue("c", ec, op_c, r1_c, r2_c, imm_c, pcout_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_halted(input int which);
    return (which == 0) ? halted_a : (which == 1) ? halted_b : halted_c;
  endfunction

  task automatic wait_halt(input int which, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sel_halted(which)) break;
      tick();
    end
    check($sformatf("halt_reached_%0d", which), 32'(sel_halted(which)), 32'd1);
  endtask

  function automatic exp_t to_exp(input vec_t v);
    return '{op: v.op, r1: v.r1, r2: v.r2, imm: v.imm, pc: v.addr};
  endfunction

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{addr: 8'd1, word: 16'h1880, op: 4'd1, r1: 3'd4, r2: 3'd2, imm: 9'h080};
    vecs[1] = '{addr: 8'd2, word: 16'h2A07, op: 4'd2, r1: 3'd5, r2: 3'd0, imm: 9'h007};
    vecs[2] = '{addr: 8'd3, word: 16'h3802, op: 4'd3, r1: 3'd4, r2: 3'd0, imm: 9'h002};
    vecs[3] = '{addr: 8'd4, word: 16'h3A03, op: 4'd3, r1: 3'd5, r2: 3'd0, imm: 9'h003};
    vecs[4] = '{addr: 8'd5, word: 16'h4202, op: 4'd4, r1: 3'd1, r2: 3'd0, imm: 9'h002};
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    foreach (vecs[i]) rom[vecs[i].addr] = vecs[i].word;

    rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b0;
    rst_c = 1'b1; start_c = 1'b0; ready_c = 1'b0;
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state
    check("rst_rom_addr", 32'(addr_a), 32'd0);
    check("rst_out_valid", 32'(valid_a), 32'd0);
    check("rst_op", 32'(op_a), 32'd0);
    check("rst_r1", 32'(r1_a), 32'd0);
    check("rst_r2", 32'(r2_a), 32'd0);
    check("rst_imm", 32'(imm_a), 32'd0);
    check("rst_pc_out", 32'(pcout_a), 32'd0);
    check("rst_halted", 32'(halted_a), 32'd0);
    check("rst_illegal", 32'(ill_a), 32'd0);

    // Default program, out_ready held high, issues spaced 3 cycles apart
    foreach (vecs[i]) qa.push_back(to_exp(vecs[i]));
    ready_a   = 1'b1;
    gap_chk_a = 1'b1;
    pulse_start_a();
    check("a_start_no_valid", 32'(valid_a), 32'd0);
    wait_halt(0, 60);
    gap_chk_a = 1'b0;
    check("a_prog_drained", 32'(qa.size()), 32'd0);
    check("a_prog_halt_addr", 32'(addr_a), 32'd6);
    check("a_prog_illegal", 32'(ill_a), 32'd0);
    check("a_prog_valid_low", 32'(valid_a), 32'd0);

    // Stall: out_ready low for 10 cycles during the first ISSUE
    reset_a();
    foreach (vecs[i]) qa.push_back(to_exp(vecs[i]));
    ready_a = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 20; i++) begin
      if (valid_a) break;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(valid_a), 32'd1);
      check("stall_op", 32'(op_a), 32'd1);
      check("stall_r1", 32'(r1_a), 32'd4);
      check("stall_r2", 32'(r2_a), 32'd2);
      check("stall_rom_addr", 32'(addr_a), 32'd1);
      tick();
    end
    ready_a = 1'b1;
    tick();
    check("valid_falls_after_hs", 32'(valid_a), 32'd0);
    check("pc_advanced_after_hs", 32'(addr_a), 32'd2);
    wait_halt(0, 60);
    check("stall_drained", 32'(qa.size()), 32'd0);

    // Illegal opcode at addr 2
    rom[2] = 16'h7000;
    reset_a();
    qa.push_back(to_exp(vecs[0]));
    ready_a = 1'b1;
    pulse_start_a();
    wait_halt(0, 60);
    check("ill_flag", 32'(ill_a), 32'd1);
    check("ill_rom_addr", 32'(addr_a), 32'd2);
    check("ill_drained", 32'(qa.size()), 32'd0);
    start_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_absorb_valid", 32'(valid_a), 32'd0);
      check("halt_absorb_halted", 32'(halted_a), 32'd1);
      check("halt_absorb_addr", 32'(addr_a), 32'd2);
    end
    start_a = 1'b0;
    rom[2] = vecs[1].word;

    // Reset during ISSUE of addr 3 with out_ready high
    reset_a();
    qa.push_back(to_exp(vecs[0]));
    qa.push_back(to_exp(vecs[1]));
    ready_a = 1'b1;
    pulse_start_a();
    for (int i = 0; i < 40; i++) begin
      if (valid_a && pcout_a == 8'd3) break;
      tick();
    end
    check("reached_issue_addr3", 32'(pcout_a), 32'd3);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("rst_issue_valid", 32'(valid_a), 32'd0);
    check("rst_issue_addr", 32'(addr_a), 32'd0);
    check("rst_issue_pc_out", 32'(pcout_a), 32'd0);
    check("rst_issue_drained", 32'(qa.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_hold_addr", 32'(addr_a), 32'd0);
      check("idle_hold_valid", 32'(valid_a), 32'd0);
    end
    foreach (vecs[i]) qa.push_back(to_exp(vecs[i]));
    pulse_start_a();
    wait_halt(0, 60);
    check("restart_drained", 32'(qa.size()), 32'd0);

    // SKIP_NOP = 0: NOPs at addr 0 and 6 are issued too
    qb.push_back('{op: 4'd0, r1: 3'd0, r2: 3'd0, imm: 9'd0, pc: 8'd0});
    foreach (vecs[i]) qb.push_back(to_exp(vecs[i]));
    qb.push_back('{op: 4'd0, r1: 3'd0, r2: 3'd0, imm: 9'd0, pc: 8'd6});
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_halt(1, 60);
    check("b_drained", 32'(qb.size()), 32'd0);
    check("b_illegal", 32'(ill_b), 32'd0);
    check("b_halt_addr", 32'(addr_b), 32'd6);

    // PC_LAST = 255: minimum latency, 256 issues, no wrap
    for (int i = 0; i < 256; i++) qc.push_back('{op: 4'd1, r1: 3'd0, r2: 3'd0, imm: 9'd0, pc: 8'(i)});
    ready_c = 1'b1;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("lat_edge_n1_valid", 32'(valid_c), 32'd0);
    tick();
    check("lat_edge_n2_valid", 32'(valid_c), 32'd0);
    tick();
    check("lat_edge_n3_valid", 32'(valid_c), 32'd1);
    check("lat_edge_n3_pc_out", 32'(pcout_c), 32'd0);
    wait_halt(2, 900);
    check("c_drained", 32'(qc.size()), 32'd0);
    check("c_halt_addr", 32'(addr_c), 32'd255);
    check("c_halt_pc_out", 32'(pcout_c), 32'd255);
    tick();
    tick();
    check("c_no_wrap_addr", 32'(addr_c), 32'd255);
    check("c_no_wrap_valid", 32'(valid_c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
